jtframe_mixer_tdm: RTL and testbench

Time-multiplexed, parametrised N-channel audio mixer for jtframe sound subsystems: it replaces fixed 4-input parallel mixers when a core has more sources (FM, ADPCM, PSG, DAC) and needs per-channel gain ramping. On each sample strobe it snapshots every channel. It then runs one multiply-accumulate per clock, saturates the result and presents a registered output with a done pulse. It also reports clipping through a held peak flag and flags strobes that arrive while a mix is in progress.

---
 rtl/jtframe_mixer_tdm.sv | 151 +++++++++++++++
 tb/tb_jtframe_mixer_tdm.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mixer_tdm.sv
// jtframe_mixer_tdm
// Time-multiplexed N-channel audio mixer. Each sample strobe snapshots every
// channel. One multiply-accumulate then runs per clock. The sum is scaled by
// 1/16 (4.4 gains), saturated and registered. Gains ramp toward their targets
// between mixes. Clipping is reported through a held peak flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for cen; snapshot channels and start a new mix
//   S_MAC  | one multiply-accumulate per clock, channel r_k
//   S_SAT  | scale the accumulator by 1/16 and clamp it to WOUT bits
//   S_OUT  | publish the result, pulse sample, step gain ramps and peak hold
module jtframe_mixer_tdm #(
   parameter int         CH       = 4,
   parameter int         W        = 16,
   parameter int         WOUT     = 16,
   parameter logic [7:0] RAMP     = 8'h01,
   parameter int         PEAKHOLD = 1024
)(
   input  logic                rst,
   input  logic                clk,
   input  logic                cen,
   input  logic [CH*W-1:0]     ch,
   input  logic [CH*8-1:0]     gain,
   output logic [WOUT-1:0]     mixed,
   output logic                sample,
   output logic                peak,
   output logic                busy,
   output logic                ovr
);

   localparam int KW = (CH > 1) ? $clog2(CH) : 1;
   localparam int PW = W + 9;
   localparam int AW = W + 9 + $clog2(CH);
   localparam int HW = (PEAKHOLD > 0) ? $clog2(PEAKHOLD + 1) : 1;

   localparam logic signed [AW-1:0] C_MAX = AW'((64'sd1 <<< (WOUT-1)) - 64'sd1);
   localparam logic signed [AW-1:0] C_MIN = AW'(-(64'sd1 <<< (WOUT-1)));

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_OUT} state_t;

   state_t                 r_state;
   logic signed [W-1:0]    r_snap [CH];
   logic [7:0]             r_gcur [CH];
   logic [KW-1:0]          r_k;
   logic signed [AW-1:0]   r_acc;
   logic signed [WOUT-1:0] r_sat;
   logic                   r_clip;
   logic [HW-1:0]          r_hold;

   logic [7:0]             w_gnext [CH];
   logic signed [PW-1:0]   w_prod;
   logic signed [AW-1:0]   w_shift;

   // Gain is unsigned 4.4, so it enters the multiply as a positive 9-bit value
   assign w_prod  = PW'(r_snap[r_k]) * PW'($signed({1'b0, r_gcur[r_k]}));
   assign w_shift = r_acc >>> 4;

   // Next ramp value per channel: step toward the target by at most RAMP
   for (genvar gi = 0; gi < CH; gi++) begin : g_ramp
      logic [7:0] w_tgt;
      logic [7:0] w_up;
      logic [7:0] w_dn;
      logic [7:0] w_step_up;
      logic [7:0] w_step_dn;
      assign w_tgt     = gain[gi*8 +: 8];
      assign w_up      = w_tgt - r_gcur[gi];
      assign w_dn      = r_gcur[gi] - w_tgt;
      assign w_step_up = (w_up > RAMP) ? RAMP : w_up;
      assign w_step_dn = (w_dn > RAMP) ? RAMP : w_dn;
      assign w_gnext[gi] = (RAMP == 8'd0)        ? w_tgt :
                           (w_tgt > r_gcur[gi]) ? r_gcur[gi] + w_step_up :
                                                  r_gcur[gi] - w_step_dn;
   end

   // Mix sequencer with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_acc   <= '0;
         r_sat   <= '0;
         r_clip  <= 1'b0;
         r_hold  <= '0;
         mixed   <= '0;
         sample  <= 1'b0;
         peak    <= 1'b0;
         busy    <= 1'b0;
         ovr     <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            r_snap[i] <= '0;
            r_gcur[i] <= '0;
         end
      end else begin
         sample <= 1'b0;
         // busy stays high through S_OUT, so a strobe on the return edge is refused too
         ovr    <= cen & busy;
         case (r_state)
            S_IDLE: begin
               if (cen) begin
                  for (int i = 0; i < CH; i++) begin
                     r_snap[i] <= $signed(ch[i*W +: W]);
                     // Without ramping the gains at the strobe apply to this very mix
                     if (RAMP == 8'd0) r_gcur[i] <= gain[i*8 +: 8];
                  end
                  r_acc   <= '0;
                  r_k     <= '0;
                  busy    <= 1'b1;
                  r_state <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + AW'(w_prod);
               if (r_k == KW'(CH-1)) r_state <= S_SAT;
               else                  r_k     <= r_k + 1'b1;
            end
            S_SAT: begin
               if (w_shift > C_MAX) begin
                  r_sat  <= WOUT'(C_MAX);
                  r_clip <= 1'b1;
               end else if (w_shift < C_MIN) begin
                  r_sat  <= WOUT'(C_MIN);
                  r_clip <= 1'b1;
               end else begin
                  r_sat  <= WOUT'(w_shift);
                  r_clip <= 1'b0;
               end
               r_state <= S_OUT;
            end
            S_OUT: begin
               mixed  <= r_sat;
               sample <= 1'b1;
               busy   <= 1'b0;
               for (int i = 0; i < CH; i++) r_gcur[i] <= w_gnext[i];
               // Peak stays up while the counter drains and drops once it is already empty
               if (r_clip) begin
                  r_hold <= HW'(PEAKHOLD);
                  peak   <= 1'b1;
               end else if (r_hold != '0) begin
                  r_hold <= r_hold - 1'b1;
               end else begin
                  peak   <= 1'b0;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtframe_mixer_tdm.sv
// Bench for jtframe_mixer_tdm: one instance without ramping, one with RAMP=1.
// Both instances share the same stimulus. Expected results come from hand
// tables and from a behavioural mixing model.
module tb_jtframe_mixer_tdm;

   localparam int CH = 4;
   localparam int W  = 16;
   localparam int WOUT = 16;
   localparam int PH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cen = 1'b0;
   logic [CH*W-1:0] ch_v   = '0;
   logic [CH*8-1:0] gain_v = '0;

   logic [WOUT-1:0] mixed0, mixed1;
   logic sample0, sample1, peak0, peak1, busy0, busy1, ovr0, ovr1;

   jtframe_mixer_tdm #(.CH(CH), .W(W), .WOUT(WOUT), .RAMP(8'h00), .PEAKHOLD(PH)) dut0 (
      .rst(rst), .clk(clk), .cen(cen), .ch(ch_v), .gain(gain_v),
      .mixed(mixed0), .sample(sample0), .peak(peak0), .busy(busy0), .ovr(ovr0));

   jtframe_mixer_tdm #(.CH(CH), .W(W), .WOUT(WOUT), .RAMP(8'h01), .PEAKHOLD(PH)) dut1 (
      .rst(rst), .clk(clk), .cen(cen), .ch(ch_v), .gain(gain_v),
      .mixed(mixed1), .sample(sample1), .peak(peak1), .busy(busy1), .ovr(ovr1));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: index 0 is the no-ramp instance, 1 the RAMP=1 instance
   int m_gcur [2][CH];
   int m_cnt  [2];
   int m_mix  [2];
   int m_pk   [2];

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0;
         m_mix[d] = 0;
         m_pk[d]  = 0;
         for (int i = 0; i < CH; i++) m_gcur[d][i] = 0;
      end
   endtask

   // Sum of sample*gain/16 rounded toward minus infinity, saturated, then
   // peak-hold bookkeeping and gain ramp for the next mix.
   task automatic model_mix(input logic [CH*W-1:0] c, input logic [CH*8-1:0] g);
      longint sum, s;
      int gt, diff;
      bit clip;
      for (int d = 0; d < 2; d++) begin
         sum = 0;
         for (int i = 0; i < CH; i++) begin
            gt = (d == 0) ? int'(g[i*8 +: 8]) : m_gcur[d][i];
            sum += longint'($signed(c[i*W +: W])) * gt;
         end
         if (sum >= 0) s = sum / 16;
         else          s = -((-sum + 15) / 16);
         clip = 1'b0;
         if (s > 32767)       begin s = 32767;  clip = 1'b1; end
         else if (s < -32768) begin s = -32768; clip = 1'b1; end
         m_mix[d] = int'(s);
         if (clip)            begin m_cnt[d] = PH; m_pk[d] = 1; end
         else if (m_cnt[d] > 0) begin m_cnt[d]--;  m_pk[d] = 1; end
         else                 m_pk[d] = 0;
         for (int i = 0; i < CH; i++) begin
            gt = int'(g[i*8 +: 8]);
            if (d == 0) m_gcur[d][i] = gt;
            else begin
               diff = gt - m_gcur[d][i];
               if (diff > 0)      m_gcur[d][i] += 1;
               else if (diff < 0) m_gcur[d][i] -= 1;
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mixed0"},  $signed(mixed0), 0);
      check({tag, "_mixed1"},  $signed(mixed1), 0);
      check({tag, "_sample0"}, sample0, 0);
      check({tag, "_sample1"}, sample1, 0);
      check({tag, "_peak0"},   peak0, 0);
      check({tag, "_peak1"},   peak1, 0);
      check({tag, "_busy0"},   busy0, 0);
      check({tag, "_busy1"},   busy1, 0);
      check({tag, "_ovr0"},    ovr0, 0);
      check({tag, "_ovr1"},    ovr1, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One full mix: strobe, wait for sample (bounded), compare with the model
   task automatic run_mix(input logic [CH*W-1:0] c, input logic [CH*8-1:0] g,
                          input string tag);
      int cyc;
      @(negedge clk);
      ch_v = c; gain_v = g; cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
      check({tag, "_busy_hi"}, busy0, 1);
      cyc = 0;
      while (!sample0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      model_mix(c, g);
      check({tag, "_latency"}, cyc, CH + 2);
      check({tag, "_sample1"}, sample1, 1);
      check({tag, "_busy_lo"}, busy0, 0);
      check({tag, "_mixed0"},  $signed(mixed0), m_mix[0]);
      check({tag, "_mixed1"},  $signed(mixed1), m_mix[1]);
      check({tag, "_peak0"},   peak0, m_pk[0]);
      check({tag, "_peak1"},   peak1, m_pk[1]);
   endtask

   typedef struct {
      logic [CH*W-1:0] c;
      logic [CH*8-1:0] g;
      logic [15:0]     exp0;
      logic            pk0;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ovr, n_samp;
      logic [CH*W-1:0] rc;
      logic [CH*8-1:0] rg;

      tbl[0] = '{ {16'h0000, 16'h0000, 16'h0000, 16'h1234}, {8'h00, 8'h00, 8'h00, 8'h10}, 16'h1234, 1'b0 };
      tbl[1] = '{ {16'h0000, 16'h0000, 16'h7000, 16'h7000}, {8'h00, 8'h00, 8'h10, 8'h10}, 16'h7FFF, 1'b1 };
      tbl[2] = '{ {16'h0000, 16'h0000, 16'hB1E0, 16'hB1E0}, {8'h00, 8'h00, 8'h10, 8'h10}, 16'h8000, 1'b1 };
      tbl[3] = '{ {16'h0000, 16'h0000, 16'h0000, 16'hFFFD}, {8'h00, 8'h00, 8'h00, 8'h08}, 16'hFFFE, 1'b1 };
      tbl[4] = '{ {16'd400,  16'hFED4, 16'd200,  16'd100},  {8'h04, 8'h08, 8'h20, 8'h10}, 16'h01C2, 1'b1 };
      tbl[5] = '{ {16'h0000, 16'h0000, 16'h0000, 16'h8000}, {8'h00, 8'h00, 8'h00, 8'hFF}, 16'h8000, 1'b1 };

      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Hand-computed vectors against the no-ramp instance, model for both
      for (int t = 0; t < 6; t++) begin
         run_mix(tbl[t].c, tbl[t].g, $sformatf("tbl%0d", t));
         check($sformatf("tbl%0d_exp0", t), mixed0, tbl[t].exp0);
         check($sformatf("tbl%0d_pk0", t), peak0, tbl[t].pk0);
      end

      // Peak hold: last vector clipped, so PH silent mixes keep peak, the next drops it
      for (int j = 1; j <= PH + 1; j++) begin
         run_mix('0, '0, $sformatf("hold%0d", j));
         check($sformatf("hold%0d_pk0", j), peak0, (j <= PH) ? 1 : 0);
      end

      // Gain ramp up then down on the RAMP=1 instance
      do_reset();
      for (int j = 1; j <= 20; j++) begin
         run_mix({48'h0, 16'd1600}, {24'h0, 8'h10}, $sformatf("rup%0d", j));
         check($sformatf("rup%0d_val", j), $signed(mixed1), 100 * ((j - 1 < 16) ? j - 1 : 16));
      end
      for (int j = 1; j <= 20; j++) begin
         run_mix({48'h0, 16'd1600}, 32'h0, $sformatf("rdn%0d", j));
         check($sformatf("rdn%0d_val", j), $signed(mixed1), 1600 - 100 * ((j - 1 < 16) ? j - 1 : 16));
      end

      // Randomised mixes against the model
      for (int j = 0; j < 30; j++) begin
         rc = {$urandom, $urandom};
         rg = $urandom;
         if (j % 3 == 0) rg = rg & 32'h1F1F1F1F;
         run_mix(rc, rg, $sformatf("rnd%0d", j));
      end

      // Overrun: second strobe two clocks after the first
      @(negedge clk);
      ch_v = {16'd10, 16'd20, 16'd30, 16'd1000}; gain_v = {8'h10, 8'h10, 8'h10, 8'h10}; cen = 1'b1;
      rc = ch_v; rg = gain_v;
      @(negedge clk);
      cen = 1'b0;
      @(negedge clk);
      ch_v = {16'h7000, 16'h7000, 16'h7000, 16'h7000}; cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
      n_ovr = 0; n_samp = 0;
      for (int j = 0; j < 15; j++) begin
         if (ovr0) n_ovr++;
         if (sample0) begin
            n_samp++;
            model_mix(rc, rg);
            check("ovr_mixed0", $signed(mixed0), m_mix[0]);
            check("ovr_mixed1", $signed(mixed1), m_mix[1]);
         end
         @(negedge clk);
      end
      check("ovr_count", n_ovr, 1);
      check("ovr_samples", n_samp, 1);

      // Strobe on the edge where the mix finishes: refused with ovr
      @(negedge clk);
      ch_v = {16'd0, 16'd0, 16'd0, 16'd800}; gain_v = {8'h00, 8'h00, 8'h00, 8'h20}; cen = 1'b1;
      rc = ch_v; rg = gain_v;
      @(negedge clk);
      cen = 1'b0;
      repeat (5) @(negedge clk);
      cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
      model_mix(rc, rg);
      check("outcen_sample", sample0, 1);
      check("outcen_ovr", ovr0, 1);
      check("outcen_mixed0", $signed(mixed0), m_mix[0]);
      check("outcen_mixed1", $signed(mixed1), m_mix[1]);
      n_ovr = 0; n_samp = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (ovr0) n_ovr++;
         if (sample0 || sample1) n_samp++;
      end
      check("outcen_noovr", n_ovr, 0);
      check("outcen_nosample", n_samp, 0);

      // Reset in the middle of MAC
      @(negedge clk);
      ch_v = {16'd0, 16'd0, 16'd0, 16'h4000}; gain_v = {8'h00, 8'h00, 8'h00, 8'h10}; cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_samp = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (sample0 || sample1) n_samp++;
      end
      check("midrst_nosample", n_samp, 0);
      run_mix({48'h0, 16'h1234}, {24'h0, 8'h10}, "postrst");
      check("postrst_exp0", mixed0, 16'h1234);
      check("postrst_exp1", $signed(mixed1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
